// File: rtl/trav_stack_ctl_pkg.sv
// rtl/trav_stack_ctl_pkg.sv - shared types and helpers for the kd-tree traversal stack controller
package trav_stack_ctl_pkg;

    localparam int NUM_RAYS    = 16;
    localparam int STACK_DEPTH = 8;
    localparam int NODE_W      = 16;
    localparam int FLOAT_W     = 32;
    localparam int RID_W       = $clog2(NUM_RAYS);
    localparam int SLOT_W      = $clog2(STACK_DEPTH);
    localparam int SP_W        = $clog2(STACK_DEPTH) + 1;
    localparam int RAM_AW      = RID_W + SLOT_W;

    typedef logic [FLOAT_W-1:0] float_t;
    typedef logic [RID_W-1:0]   ray_id_t;
    typedef logic [NODE_W-1:0]  node_id_t;
    typedef logic [SLOT_W-1:0]  slot_t;
    typedef logic [SP_W-1:0]    sp_t;

    localparam sp_t SP_FULL = sp_t'(STACK_DEPTH);

    typedef struct packed {
        node_id_t node;
        float_t   t_min;
        float_t   t_max;
    } trav_stack_entry_t;

    typedef enum logic [2:0] {
        CASE_ONLY_LOW,
        CASE_ONLY_HIGH,
        CASE_LO_THEN_HI,
        CASE_HI_THEN_LO,
        CASE_ERR
    } split_case_e;

    function automatic split_case_e decode_case(input logic only_low, input logic only_high,
                                                input logic lo_then_hi, input logic hi_then_lo);
        case ({only_low, only_high, lo_then_hi, hi_then_lo})
            4'b1000: return CASE_ONLY_LOW;
            4'b0100: return CASE_ONLY_HIGH;
            4'b0010: return CASE_LO_THEN_HI;
            4'b0001: return CASE_HI_THEN_LO;
            default: return CASE_ERR;
        endcase
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/trav_stack_ram.sv
// rtl/trav_stack_ram.sv - 1W1R synchronous stack RAM addressed {ray, slot}, read latency 1
module trav_stack_ram
    import trav_stack_ctl_pkg::*;
(
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [RAM_AW-1:0] waddr_i,
    input  trav_stack_entry_t wdata_i,
    input  logic [RAM_AW-1:0] raddr_i,
    output trav_stack_entry_t rdata_o
);

    trav_stack_entry_t mem [NUM_RAYS*STACK_DEPTH];
    trav_stack_entry_t rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        rdata_q <= mem[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/trav_stack_ctl.sv
// rtl/trav_stack_ctl.sv - per-ray near/far traversal stack controller; TRAV_STACK_STATS_EN adds statistics outputs
module trav_stack_ctl
    import trav_stack_ctl_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     in_valid,
    output logic     in_ready,
    input  ray_id_t  in_ray_id,
    input  node_id_t in_lo_node,
    input  node_id_t in_hi_node,
    input  logic     in_only_low,
    input  logic     in_only_high,
    input  logic     in_lo_then_hi,
    input  logic     in_hi_then_lo,
    input  float_t   in_t_min,
    input  float_t   in_t_mid,
    input  float_t   in_t_max,
    output logic     out_valid,
    input  logic     out_ready,
    output ray_id_t  out_ray_id,
    output node_id_t out_node,
    output float_t   out_t_min,
    output float_t   out_t_max,
    output logic     out_case_err,
    input  logic     pop_valid,
    input  ray_id_t  pop_ray_id,
    output logic     pop_resp_valid,
    output node_id_t pop_resp_node,
    output float_t   pop_resp_t_min,
    output float_t   pop_resp_t_max,
    output logic     pop_resp_empty,
    output logic     pop_resp_restart,
    input  logic     init_valid,
    input  ray_id_t  init_ray_id
`ifdef TRAV_STACK_STATS_EN
    ,
    output logic [31:0]   stat_pushes,
    output logic [31:0]   stat_overflows,
    output logic [31:0]   stat_empty_pops,
    output logic [SP_W-1:0] stat_max_sp
`endif
);

    logic out_valid_q, out_case_err_q;
    ray_id_t out_ray_id_q;
    node_id_t out_node_q;
    float_t out_t_min_q, out_t_max_q;
    logic pop_valid_q, pop_empty_q, pop_restart_q;

    slot_t wr_ptr_q [NUM_RAYS];
    slot_t wr_ptr_d [NUM_RAYS];
    sp_t   sp_q [NUM_RAYS];
    sp_t   sp_d [NUM_RAYS];
    logic [NUM_RAYS-1:0] ovf_q, ovf_d;

    split_case_e case_sel;
    logic accept, push_req, push_en, pop_empty, push_ovf;
    node_id_t dec_node;
    float_t dec_t_max;
    trav_stack_entry_t push_entry, ram_rdata;
    slot_t pop_slot, push_slot;
    sp_t pop_sp, push_sp;

    assign in_ready = ~out_valid_q | out_ready;
    assign accept   = in_valid & in_ready;

    always_comb begin
        case_sel   = decode_case(in_only_low, in_only_high, in_lo_then_hi, in_hi_then_lo);
        dec_node   = in_lo_node;
        dec_t_max  = in_t_max;
        push_req   = 1'b0;
        push_entry = '{node: in_hi_node, t_min: in_t_mid, t_max: in_t_max};
        case (case_sel)
            CASE_ONLY_HIGH: dec_node = in_hi_node;
            CASE_LO_THEN_HI: begin
                dec_t_max = in_t_mid;
                push_req  = 1'b1;
            end
            CASE_HI_THEN_LO: begin
                dec_node        = in_hi_node;
                dec_t_max       = in_t_mid;
                push_req        = 1'b1;
                push_entry.node = in_lo_node;
            end
            default: ;
        endcase
    end

    // init on the same ray wins over a push; the stack is being recycled for a new ray
    assign push_en = accept & push_req & ~(init_valid & (init_ray_id == in_ray_id));

    // Pop is applied before push so a (disallowed) same-ray collision sees pre-push state
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        sp_d      = sp_q;
        ovf_d     = ovf_q;
        pop_sp    = sp_q[pop_ray_id];
        pop_empty = (pop_sp == '0);
        pop_slot  = wr_ptr_q[pop_ray_id] - 1'b1;
        if (pop_valid && !pop_empty) begin
            wr_ptr_d[pop_ray_id] = pop_slot;
            sp_d[pop_ray_id]     = pop_sp - 1'b1;
        end
        push_slot = wr_ptr_d[in_ray_id];
        push_ovf  = (sp_d[in_ray_id] == SP_FULL);
        push_sp   = push_ovf ? SP_FULL : sp_d[in_ray_id] + 1'b1;
        if (push_en) begin
            wr_ptr_d[in_ray_id] = push_slot + 1'b1;
            sp_d[in_ray_id]     = push_sp;
            if (push_ovf) begin
                ovf_d[in_ray_id] = 1'b1;
            end
        end
        if (init_valid) begin
            wr_ptr_d[init_ray_id] = '0;
            sp_d[init_ray_id]     = '0;
            ovf_d[init_ray_id]    = 1'b0;
        end
    end

    trav_stack_ram u_ram (
        .clk_i   (clk),
        .we_i    (push_en),
        .waddr_i ({in_ray_id, push_slot}),
        .wdata_i (push_entry),
        .raddr_i ({pop_ray_id, pop_slot}),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q    <= 1'b0;
            out_case_err_q <= 1'b0;
            out_ray_id_q   <= '0;
            out_node_q     <= '0;
            out_t_min_q    <= '0;
            out_t_max_q    <= '0;
            pop_valid_q    <= 1'b0;
            pop_empty_q    <= 1'b0;
            pop_restart_q  <= 1'b0;
            ovf_q          <= '0;
            for (int r = 0; r < NUM_RAYS; r++) begin
                wr_ptr_q[r] <= '0;
                sp_q[r]     <= '0;
            end
        end else begin
            if (accept) begin
                out_valid_q    <= 1'b1;
                out_case_err_q <= (case_sel == CASE_ERR);
                out_ray_id_q   <= in_ray_id;
                out_node_q     <= dec_node;
                out_t_min_q    <= in_t_min;
                out_t_max_q    <= dec_t_max;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
            pop_valid_q   <= pop_valid;
            pop_empty_q   <= pop_valid & pop_empty;
            pop_restart_q <= pop_valid & pop_empty & ovf_q[pop_ray_id];
            wr_ptr_q      <= wr_ptr_d;
            sp_q          <= sp_d;
            ovf_q         <= ovf_d;
        end
    end

    assign out_valid        = out_valid_q;
    assign out_case_err     = out_case_err_q;
    assign out_ray_id       = out_ray_id_q;
    assign out_node         = out_node_q;
    assign out_t_min        = out_t_min_q;
    assign out_t_max        = out_t_max_q;
    assign pop_resp_valid   = pop_valid_q;
    assign pop_resp_empty   = pop_empty_q;
    assign pop_resp_restart = pop_restart_q;
    // RAM output is unreset; mask it so idle/empty responses read as zero
    assign pop_resp_node    = (pop_valid_q & ~pop_empty_q) ? ram_rdata.node  : '0;
    assign pop_resp_t_min   = (pop_valid_q & ~pop_empty_q) ? ram_rdata.t_min : '0;
    assign pop_resp_t_max   = (pop_valid_q & ~pop_empty_q) ? ram_rdata.t_max : '0;

    same_ray_push_pop_a: assert property (@(posedge clk) disable iff (rst)
        !(push_en && pop_valid && (pop_ray_id == in_ray_id)));

`ifdef TRAV_STACK_STATS_EN
    logic [31:0] stat_pushes_q, stat_overflows_q, stat_empty_pops_q;
    sp_t stat_max_sp_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_pushes_q     <= '0;
            stat_overflows_q  <= '0;
            stat_empty_pops_q <= '0;
            stat_max_sp_q     <= '0;
        end else begin
            if (push_en) begin
                stat_pushes_q <= sat_inc(stat_pushes_q);
                if (push_ovf) begin
                    stat_overflows_q <= sat_inc(stat_overflows_q);
                end
                if (push_sp > stat_max_sp_q) begin
                    stat_max_sp_q <= push_sp;
                end
            end
            if (pop_valid && pop_empty) begin
                stat_empty_pops_q <= sat_inc(stat_empty_pops_q);
            end
        end
    end

    assign stat_pushes     = stat_pushes_q;
    assign stat_overflows  = stat_overflows_q;
    assign stat_empty_pops = stat_empty_pops_q;
    assign stat_max_sp     = stat_max_sp_q;
`endif

endmodule
